// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel divides clk_in by scale*BASE
// with near-50% duty, per-channel enable, and a scale change that lands on a period boundary.
module clock_divider_multi #(
  parameter int CHANNELS    = 4,
  parameter int SCALE_W     = 8,
  parameter int BASE        = 392160,
  parameter int DIV_W       = 32,
  parameter int RESET_SCALE = 255,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [SCALE_W-1:0]  cfg_scale,
  output logic [CHANNELS-1:0] cfg_pending,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [SCALE_W-1:0] RST_SCALE = SCALE_W'(RESET_SCALE);

  function automatic logic [DIV_W-1:0] divisor(input logic [SCALE_W-1:0] s);
    return DIV_W'(s) * DIV_W'(BASE);
  endfunction

  function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
    return d - (d >> 1);
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SCALE_W-1:0] shadow_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   high_q;
    logic [DIV_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   next_div;
    logic               out_q;
    logic               tick_q;
    logic               pending_q;
    logic               bypass;
    logic               write_hit;
    logic               at_end;
    logic               apply;

    // Divisors below 2 cannot be produced by the counter, so the channel passes clk_in through.
    assign bypass    = (div_q < DIV_W'(2));
    assign write_hit = cfg_we && (cfg_ch == CH_W'(i));
    assign at_end    = (cnt_q == div_q - DIV_W'(1));
    assign apply     = pending_q && (bypass || !en[i] || at_end);
    assign next_div  = divisor(shadow_q);

    always_ff @(posedge clk_in) begin
      if (rst) begin
        shadow_q  <= RST_SCALE;
        div_q     <= divisor(RST_SCALE);
        high_q    <= high_len(divisor(RST_SCALE));
        cnt_q     <= '0;
        out_q     <= 1'b0;
        tick_q    <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        if (apply) begin
          div_q     <= next_div;
          high_q    <= high_len(next_div);
          pending_q <= 1'b0;
        end
        // A write landing on the apply cycle stays pending for the following boundary.
        if (write_hit) begin
          shadow_q  <= cfg_scale;
          pending_q <= 1'b1;
        end
        if (!en[i] || bypass) begin
          cnt_q  <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          cnt_q  <= at_end ? '0 : cnt_q + DIV_W'(1);
          out_q  <= (cnt_q < high_q);
          tick_q <= (cnt_q == '0);
        end
      end
    end

    assign clk_out[i]     = bypass ? (clk_in & en[i]) : out_q;
    assign tick[i]        = bypass ? en[i] : tick_q;
    assign cfg_pending[i] = pending_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: stimulus pushes per-cycle expectations,
// two monitors (high phase and low phase of clk_in) pop and compare them.
module tb_clock_divider_multi;

  localparam int NCH = 3;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_scale;
  logic [NCH-1:0] cfg_pending;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  typedef struct {
    int   cyc;
    bit   neg;
    int   ch;
    int   kind;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Three channels so that cfg_ch=3 is representable yet out of range.
  clock_divider_multi #(
    .CHANNELS(NCH), .SCALE_W(8), .BASE(1), .DIV_W(32), .RESET_SCALE(4)
  ) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_scale(cfg_scale), .cfg_pending(cfg_pending), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
    #2;
  endtask

  task automatic applyStimulus(input logic we, input int ch, input int scale);
    cfg_we    = we;
    cfg_ch    = 2'(ch);
    cfg_scale = 8'(scale);
  endtask

  task automatic expectOut(input int c, input bit n, input int ch, input logic o, input logic t);
    sb.push_back('{cyc: c, neg: n, ch: ch, kind: 0, val: o});
    sb.push_back('{cyc: c, neg: n, ch: ch, kind: 1, val: t});
  endtask

  task automatic expectPend(input int c, input int ch, input logic p);
    sb.push_back('{cyc: c, neg: 1'b0, ch: ch, kind: 2, val: p});
  endtask

  // Waveform of a running divider: tick and high for hi cycles, then low for lo cycles.
  task automatic expectPattern(input int ch, input int start, input int hi, input int lo, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int ph;
      ph = k % (hi + lo);
      expectOut(start + k, 1'b0, ch, ph < hi, ph == 0);
    end
  endtask

  task automatic checkOutput(input bit neg);
    string nm;
    logic  act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missed_check ch%0d cyc%0d kind%0d never sampled", sb[i].ch, sb[i].cyc, sb[i].kind);
        sb.delete(i);
      end else if (sb[i].cyc == cyc && sb[i].neg == neg) begin
        case (sb[i].kind)
          0:       begin act = clk_out[sb[i].ch];     nm = "clk_out";     end
          1:       begin act = tick[sb[i].ch];        nm = "tick";        end
          default: begin act = cfg_pending[sb[i].ch]; nm = "cfg_pending"; end
        endcase
        checks++;
        if (act !== sb[i].val) begin
          failures++;
          $display("[TB] FAIL %s ch%0d cyc%0d neg%0d got %b expected %b",
                   nm, sb[i].ch, cyc, neg, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    #1;
    checkOutput(1'b0);
  end

  initial forever begin
    @(negedge clk_in);
    #1;
    checkOutput(1'b1);
  end

  initial begin
    rst = 1'b1;
    en  = '0;
    applyStimulus(1'b0, 0, 0);

    for (int ch = 0; ch < NCH; ch++) begin
      for (int c = 1; c <= 2; c++) begin
        expectOut(c, 1'b0, ch, 1'b0, 1'b0);
        expectPend(c, ch, 1'b0);
      end
    end
    expectPattern(0, 3, 2, 2, 16);
    expectPattern(1, 3, 2, 2, 12);
    expectPattern(2, 3, 2, 2, 59);

    stepTo(2);
    rst = 1'b0;
    en  = 3'b111;

    // ch1 -> scale 5 at its next boundary
    stepTo(11);
    expectPend(12, 1, 1'b1);
    expectPend(13, 1, 1'b1);
    expectPend(14, 1, 1'b0);
    expectPattern(1, 15, 3, 2, 31);
    applyStimulus(1'b1, 1, 5);
    stepTo(12);
    applyStimulus(1'b0, 0, 0);

    // ch0: 6 then 8 inside one period, only 8 is applied
    stepTo(15);
    expectPend(16, 0, 1'b1);
    expectPend(17, 0, 1'b1);
    expectPend(18, 0, 1'b0);
    expectPattern(0, 19, 4, 4, 15);
    applyStimulus(1'b1, 0, 6);
    stepTo(16);
    applyStimulus(1'b1, 0, 8);
    stepTo(17);
    applyStimulus(1'b0, 0, 0);

    // ch0 -> scale 0 (bypass) at the boundary
    stepTo(29);
    for (int c = 30; c <= 33; c++) expectPend(c, 0, 1'b1);
    expectPend(34, 0, 1'b0);
    for (int c = 34; c <= 38; c++) begin
      expectOut(c, 1'b0, 0, 1'b1, 1'b1);
      expectOut(c, 1'b1, 0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 0, 0);
    stepTo(30);
    applyStimulus(1'b0, 0, 0);

    // ch0 bypass -> scale 3 applies on the next cycle
    stepTo(37);
    expectPend(38, 0, 1'b1);
    expectPend(39, 0, 1'b0);
    expectOut(39, 1'b0, 0, 1'b0, 1'b0);
    expectPattern(0, 40, 2, 1, 22);
    applyStimulus(1'b1, 0, 3);
    stepTo(38);
    applyStimulus(1'b0, 0, 0);

    // ch1 disabled during its high phase, then re-enabled
    stepTo(45);
    for (int c = 46; c <= 49; c++) expectOut(c, 1'b0, 1, 1'b0, 1'b0);
    expectPattern(1, 50, 3, 2, 12);
    en = 3'b101;
    stepTo(49);
    en = 3'b111;

    stepTo(51);
    for (int ch = 0; ch < NCH; ch++) begin
      expectPend(52, ch, 1'b0);
      expectPend(53, ch, 1'b0);
    end
    applyStimulus(1'b1, 3, 1);
    stepTo(52);
    applyStimulus(1'b0, 0, 0);

    // reset mid-period while ch2 has a pending write
    stepTo(60);
    expectPend(61, 2, 1'b1);
    applyStimulus(1'b1, 2, 7);
    stepTo(61);
    applyStimulus(1'b0, 0, 0);
    rst = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      expectOut(62, 1'b0, ch, 1'b0, 1'b0);
      for (int c = 62; c <= 66; c++) expectPend(c, ch, 1'b0);
      expectPattern(ch, 63, 2, 2, 12);
    end
    stepTo(62);
    rst = 1'b0;

    stepTo(80);
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unchecked ch%0d cyc%0d kind%0d", sb[0].ch, sb[0].cyc, sb[0].kind);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
